// File: rtl/scr1_tcm_mp.sv
// Multi-port TCM: dedicated instruction read port A, and a data port B shared
// by the core data port and ACC_PORTS accelerators through a one-cycle arbiter.

package scr1_memif_pkg;
    localparam int SCR1_IMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_AWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_tcm_mp
    import scr1_memif_pkg::*;
#(
    parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
    parameter int          ACC_PORTS     = 2,
    parameter int          CORE_PRIO     = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           imem_req,
    input  type_scr1_mem_cmd_e                             imem_cmd,
    input  logic [SCR1_IMEM_AWIDTH-1:0]                    imem_addr,
    output logic                                           imem_req_ack,
    output logic [31:0]                                    imem_rdata,
    output type_scr1_mem_resp_e                            imem_resp,
    input  logic                                           dmem_req,
    input  type_scr1_mem_cmd_e                             dmem_cmd,
    input  type_scr1_mem_width_e                           dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]                    dmem_addr,
    input  logic [31:0]                                    dmem_wdata,
    output logic                                           dmem_req_ack,
    output logic [31:0]                                    dmem_rdata,
    output type_scr1_mem_resp_e                            dmem_resp,
    input  logic [ACC_PORTS-1:0]                           acc_req,
    input  logic [ACC_PORTS-1:0]                           acc_we,
    input  logic [ACC_PORTS*($clog2(SCR1_TCM_SIZE)-2)-1:0] acc_addr,
    input  logic [ACC_PORTS*32-1:0]                        acc_wdata,
    input  logic [ACC_PORTS*4-1:0]                         acc_be,
    output logic [ACC_PORTS-1:0]                           acc_ack,
    output logic [ACC_PORTS-1:0]                           acc_rvalid,
    output logic [31:0]                                    acc_rdata
);
    localparam int AW     = $clog2(SCR1_TCM_SIZE);
    localparam int WA     = AW - 2;
    localparam int DEPTH  = 1 << WA;
    localparam int NREQ   = ACC_PORTS + 1;
    // In core-priority mode the core bypasses the ring, so only accelerators rotate.
    localparam int RR_CNT = (CORE_PRIO != 0) ? ACC_PORTS : NREQ;
    localparam int PW     = $clog2(ACC_PORTS + 2);

    logic [NREQ-1:0]     req_vec;
    logic [NREQ-1:0]     gnt_vec;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                core_gnt, core_mis;
    logic                b_en, b_we;
    logic [WA-1:0]       b_addr;
    logic [3:0]          b_be;
    logic [31:0]         b_wdata;
    logic [31:0]         rdata_a, rdata_b;
    type_scr1_mem_resp_e dmem_resp_q, dmem_resp_d;
    type_scr1_mem_resp_e imem_resp_q, imem_resp_d;
    logic [ACC_PORTS-1:0] acc_rvalid_q, acc_rvalid_d;
    logic [1:0]          shift_q, shift_d;
    logic                unused_bits;

    // Arbiter: core priority override, then round-robin search from the pointer.
    always_comb begin
        int idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        req_vec  = {dmem_req, acc_req};
        gnt_vec  = '0;
        rr_ptr_d = rr_ptr_q;
        if ((CORE_PRIO != 0) && dmem_req) begin
            gnt_vec[ACC_PORTS] = 1'b1;
        end else begin
            for (int k = 0; k < RR_CNT; k++) begin
                idx = (int'(rr_ptr_q) + k) % RR_CNT;
                if (!found && req_vec[idx]) begin
                    found        = 1'b1;
                    gnt_vec[idx] = 1'b1;
                    rr_ptr_d     = PW'((idx + 1) % RR_CNT);
                end
            end
        end
    end

    assign core_gnt     = gnt_vec[ACC_PORTS];
    assign dmem_req_ack = core_gnt;
    assign acc_ack      = gnt_vec[ACC_PORTS-1:0];
    assign imem_req_ack = 1'b1;

    // Port-B command mux: alignment check and byte-lane steering for the winner.
    always_comb begin
        core_mis = 1'b0;
        b_en     = 1'b0;
        b_we     = 1'b0;
        b_addr   = '0;
        b_be     = 4'h0;
        b_wdata  = '0;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  core_mis = 1'b0;
            SCR1_MEM_WIDTH_HWORD: core_mis = dmem_addr[0];
            default:              core_mis = |dmem_addr[1:0];
        endcase
        if (core_gnt) begin
            b_en   = !core_mis;
            b_we   = !core_mis && (dmem_cmd == SCR1_MEM_CMD_WR);
            b_addr = dmem_addr[AW-1:2];
            case (dmem_width)
                SCR1_MEM_WIDTH_BYTE: begin
                    b_be    = 4'b0001 << dmem_addr[1:0];
                    b_wdata = {4{dmem_wdata[7:0]}};
                end
                SCR1_MEM_WIDTH_HWORD: begin
                    b_be    = 4'b0011 << {dmem_addr[1], 1'b0};
                    b_wdata = {2{dmem_wdata[15:0]}};
                end
                default: begin
                    b_be    = 4'hF;
                    b_wdata = dmem_wdata;
                end
            endcase
        end
        for (int i = 0; i < ACC_PORTS; i++) begin
            if (gnt_vec[i]) begin
                b_en    = 1'b1;
                b_we    = acc_we[i];
                b_addr  = acc_addr[i*WA +: WA];
                b_be    = acc_be[i*4 +: 4];
                b_wdata = acc_wdata[i*32 +: 32];
            end
        end
    end

    // Next response state: what was accepted this cycle answers in the next.
    always_comb begin
        dmem_resp_d  = SCR1_MEM_RESP_NOTRDY;
        if (core_gnt) begin
            dmem_resp_d = core_mis ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        end
        imem_resp_d  = imem_req ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
        acc_rvalid_d = gnt_vec[ACC_PORTS-1:0];
        shift_d      = core_gnt ? dmem_addr[1:0] : shift_q;
    end

    // Response, shift and pointer registers; reset kills in-flight responses at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_resp_q  <= SCR1_MEM_RESP_NOTRDY;
            imem_resp_q  <= SCR1_MEM_RESP_NOTRDY;
            acc_rvalid_q <= '0;
            shift_q      <= 2'b00;
            rr_ptr_q     <= '0;
        end else begin
            dmem_resp_q  <= dmem_resp_d;
            imem_resp_q  <= imem_resp_d;
            acc_rvalid_q <= acc_rvalid_d;
            shift_q      <= shift_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // One byte-wide dual-port array per lane; reads are registered, so port A
    // sees the pre-write value when both ports touch the same word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_b [DEPTH];
        logic [7:0] rd_a_q, rd_b_q;

        // Lane storage with port-B write and both registered reads.
        always_ff @(posedge clk) begin
            if (b_en && b_we && b_be[gi]) begin
                mem_b[b_addr] <= b_wdata[gi*8 +: 8];
            end
            if (b_en) begin
                rd_b_q <= mem_b[b_addr];
            end
            if (imem_req) begin
                rd_a_q <= mem_b[imem_addr[AW-1:2]];
            end
        end

        assign rdata_a[gi*8 +: 8] = rd_a_q;
        assign rdata_b[gi*8 +: 8] = rd_b_q;
    end

    assign imem_rdata = rdata_a;
    assign imem_resp  = imem_resp_q;
    assign dmem_rdata = rdata_b >> {shift_q, 3'b000};
    assign dmem_resp  = dmem_resp_q;
    assign acc_rdata  = rdata_b;
    assign acc_rvalid = acc_rvalid_q;

    assign unused_bits = ^{imem_cmd, imem_addr[SCR1_IMEM_AWIDTH-1:AW], imem_addr[1:0],
                           dmem_addr[SCR1_DMEM_AWIDTH-1:AW]};

endmodule

// File: tb/tb_scr1_tcm_mp.sv
// Directed bench for scr1_tcm_mp: one core-priority and one round-robin instance
// driven by the same stimulus, checked against hand-computed expectations.
module tb_scr1_tcm_mp;
    import scr1_memif_pkg::*;

    localparam logic [1:0] BY = 2'b00, HW = 2'b01, WD = 2'b10;
    localparam logic [1:0] NR = 2'b00, OK = 2'b01, ER = 2'b10;
    localparam int NV = 19;

    typedef struct {
        logic        dreq; logic dwr; logic [1:0] dw; logic [31:0] dad; logic [31:0] dwd;
        logic [1:0]  areq; logic [1:0] awe; logic [13:0] aad; logic [31:0] awd; logic [3:0] abe;
        logic        ireq; logic [31:0] iad;
        logic        xdack; logic [1:0] xaack; logic [1:0] xdresp; logic [1:0] xarv;
        logic [31:0] xdrd; logic [31:0] mdrd; logic [31:0] xard; logic [31:0] mard;
        logic [1:0]  xiresp; logic [31:0] xird;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic imem_req = 1'b0;
    logic [31:0] imem_addr = '0;
    logic dmem_req = 1'b0;
    logic dmem_wr = 1'b0;
    logic [1:0] dmem_w = WD;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [1:0] acc_req = '0;
    logic [1:0] acc_we = '0;
    logic [27:0] acc_addr = '0;
    logic [63:0] acc_wdata = '0;
    logic [7:0] acc_be = '0;

    type_scr1_mem_cmd_e   imem_cmd, dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    assign imem_cmd   = SCR1_MEM_CMD_RD;
    assign dmem_cmd   = type_scr1_mem_cmd_e'(dmem_wr);
    assign dmem_width = type_scr1_mem_width_e'(dmem_w);

    logic iack_p, iack_r, dack_p, dack_r;
    logic [31:0] irdata_p, irdata_r, drdata_p, drdata_r, ardata_p, ardata_r;
    type_scr1_mem_resp_e iresp_p, iresp_r, dresp_p, dresp_r;
    logic [1:0] aack_p, aack_r, arv_p, arv_r;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scr1_tcm_mp #(.SCR1_TCM_SIZE(32'h00010000), .ACC_PORTS(2), .CORE_PRIO(1)) u_dut_prio (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_cmd(imem_cmd), .imem_addr(imem_addr),
        .imem_req_ack(iack_p), .imem_rdata(irdata_p), .imem_resp(iresp_p),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dack_p), .dmem_rdata(drdata_p), .dmem_resp(dresp_p),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_be(acc_be),
        .acc_ack(aack_p), .acc_rvalid(arv_p), .acc_rdata(ardata_p)
    );

    scr1_tcm_mp #(.SCR1_TCM_SIZE(32'h00010000), .ACC_PORTS(2), .CORE_PRIO(0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_cmd(imem_cmd), .imem_addr(imem_addr),
        .imem_req_ack(iack_r), .imem_rdata(irdata_r), .imem_resp(iresp_r),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dack_r), .dmem_rdata(drdata_r), .dmem_resp(dresp_r),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_be(acc_be),
        .acc_ack(aack_r), .acc_rvalid(arv_r), .acc_rdata(ardata_r)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req = 1'b0; dmem_req = 1'b0; dmem_wr = 1'b0; dmem_w = WD;
        acc_req = 2'b00; acc_we = 2'b00;
    endtask

    vec_t vecs [NV];

    initial begin
        // dreq dwr dw dad dwd | areq awe aad awd abe | ireq iad | xdack xaack xdresp xarv | xdrd mdrd | xard mard | xiresp xird
        vecs[0]  = '{1,1,WD,32'h10,32'hDEADBEEF, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 1,2'b00,NR,2'b00, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[1]  = '{1,0,BY,32'h13,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 1,2'b00,OK,2'b00, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[2]  = '{1,1,WD,32'h20,32'h12345678, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 1,2'b00,OK,2'b00, 32'hDE,32'hFF, 32'h0,32'h0, NR,32'h0};
        vecs[3]  = '{1,1,HW,32'h21,32'h0000AAAA, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 1,2'b00,OK,2'b00, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[4]  = '{1,0,WD,32'h20,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 1,2'b00,ER,2'b00, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[5]  = '{0,0,WD,32'h0,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 1,32'h10, 0,2'b00,OK,2'b00, 32'h12345678,32'hFFFFFFFF, 32'h0,32'h0, NR,32'h0};
        vecs[6]  = '{1,0,WD,32'h10,32'h0, 2'b11,2'b00,14'd5,32'h0,4'h0, 0,32'h0, 1,2'b00,NR,2'b00, 32'h0,32'h0, 32'h0,32'h0, OK,32'hDEADBEEF};
        vecs[7]  = '{1,0,WD,32'h10,32'h0, 2'b11,2'b00,14'd5,32'h0,4'h0, 0,32'h0, 1,2'b00,OK,2'b00, 32'hDEADBEEF,32'hFFFFFFFF, 32'h0,32'h0, NR,32'h0};
        vecs[8]  = '{0,0,WD,32'h0,32'h0, 2'b11,2'b00,14'd4,32'h0,4'h0, 0,32'h0, 0,2'b01,OK,2'b00, 32'hDEADBEEF,32'hFFFFFFFF, 32'h0,32'h0, NR,32'h0};
        vecs[9]  = '{0,0,WD,32'h0,32'h0, 2'b11,2'b00,14'd4,32'h0,4'h0, 0,32'h0, 0,2'b10,NR,2'b01, 32'h0,32'h0, 32'hDEADBEEF,32'hFFFFFFFF, NR,32'h0};
        vecs[10] = '{0,0,WD,32'h0,32'h0, 2'b11,2'b00,14'd4,32'h0,4'h0, 0,32'h0, 0,2'b01,NR,2'b10, 32'h0,32'h0, 32'hDEADBEEF,32'hFFFFFFFF, NR,32'h0};
        vecs[11] = '{0,0,WD,32'h0,32'h0, 2'b10,2'b11,14'd5,32'hFFFFFFFF,4'hF, 0,32'h0, 0,2'b10,NR,2'b01, 32'h0,32'h0, 32'hDEADBEEF,32'hFFFFFFFF, NR,32'h0};
        vecs[12] = '{0,0,WD,32'h0,32'h0, 2'b10,2'b11,14'd5,32'h11223344,4'b0101, 0,32'h0, 0,2'b10,NR,2'b10, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[13] = '{0,0,WD,32'h0,32'h0, 2'b10,2'b00,14'd5,32'h0,4'h0, 0,32'h0, 0,2'b10,NR,2'b10, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[14] = '{0,0,WD,32'h0,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 0,2'b00,NR,2'b10, 32'h0,32'h0, 32'hFF22FF44,32'hFFFFFFFF, NR,32'h0};
        vecs[15] = '{1,1,WD,32'h10,32'h55555555, 2'b00,2'b00,14'd0,32'h0,4'h0, 1,32'h10, 1,2'b00,NR,2'b00, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};
        vecs[16] = '{0,0,WD,32'h0,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 1,32'h10, 0,2'b00,OK,2'b00, 32'h0,32'h0, 32'h0,32'h0, OK,32'hDEADBEEF};
        vecs[17] = '{0,0,WD,32'h0,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 0,2'b00,NR,2'b00, 32'h0,32'h0, 32'h0,32'h0, OK,32'h55555555};
        vecs[18] = '{0,0,WD,32'h0,32'h0, 2'b00,2'b00,14'd0,32'h0,4'h0, 0,32'h0, 0,2'b00,NR,2'b00, 32'h0,32'h0, 32'h0,32'h0, NR,32'h0};

        // Reset state.
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_dresp_p", 32'(dresp_p), 32'(NR));
        chk("rst_iresp_p", 32'(iresp_p), 32'(NR));
        chk("rst_arv_p", 32'(arv_p), 32'h0);
        chk("rst_dresp_r", 32'(dresp_r), 32'(NR));
        chk("rst_arv_r", 32'(arv_r), 32'h0);
        chk("rst_iack", 32'(iack_p), 32'h1);
        $display("reset: state checked");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven vectors on the core-priority instance.
        for (int v = 0; v < NV; v++) begin
            dmem_req = vecs[v].dreq; dmem_wr = vecs[v].dwr; dmem_w = vecs[v].dw;
            dmem_addr = vecs[v].dad; dmem_wdata = vecs[v].dwd;
            acc_req = vecs[v].areq; acc_we = vecs[v].awe;
            acc_addr = {2{vecs[v].aad}}; acc_wdata = {2{vecs[v].awd}}; acc_be = {2{vecs[v].abe}};
            imem_req = vecs[v].ireq; imem_addr = vecs[v].iad;
            @(negedge clk);
            chk($sformatf("v%0d_dack", v), 32'(dack_p), 32'(vecs[v].xdack));
            chk($sformatf("v%0d_aack", v), 32'(aack_p), 32'(vecs[v].xaack));
            chk($sformatf("v%0d_dresp", v), 32'(dresp_p), 32'(vecs[v].xdresp));
            chk($sformatf("v%0d_arv", v), 32'(arv_p), 32'(vecs[v].xarv));
            chk($sformatf("v%0d_iresp", v), 32'(iresp_p), 32'(vecs[v].xiresp));
            if (vecs[v].mdrd != 0)
                chk($sformatf("v%0d_drdata", v), drdata_p & vecs[v].mdrd, vecs[v].xdrd & vecs[v].mdrd);
            if (vecs[v].mard != 0)
                chk($sformatf("v%0d_ardata", v), ardata_p & vecs[v].mard, vecs[v].xard & vecs[v].mard);
            if (vecs[v].xiresp == OK)
                chk($sformatf("v%0d_irdata", v), irdata_p, vecs[v].xird);
            $display("vec %0d: dack=%0b aack=%b dresp=%0d arv=%b iresp=%0d",
                     v, dack_p, aack_p, dresp_p, arv_p, iresp_p);
            @(posedge clk); #1;
        end

        // Reset asserted the cycle after an accepted read drops the response at once.
        idle_inputs();
        dmem_req = 1'b1; dmem_w = WD; dmem_addr = 32'h10;
        @(negedge clk);
        chk("mid_dack", 32'(dack_p), 32'h1);
        @(posedge clk); #1;
        dmem_req = 1'b0;
        chk("mid_resp_before", 32'(dresp_p), 32'(OK));
        rst_n = 1'b0;
        #1;
        chk("mid_resp_async_p", 32'(dresp_p), 32'(NR));
        chk("mid_resp_async_r", 32'(dresp_r), 32'(NR));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_dresp", c), 32'(dresp_p), 32'(NR));
            chk($sformatf("post_rst%0d_arv", c), 32'(arv_p), 32'h0);
        end
        $display("reset mid-operation: sequence checked");
        @(posedge clk); #1;

        // All three requesters active: round-robin instance rotates acc0, acc1, core.
        begin
            logic [1:0] x_aack [7];
            logic       x_dack [7];
            logic [1:0] x_arv  [7];
            logic [1:0] x_dres [7];
            x_aack = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
            x_dack = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            x_arv  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
            x_dres = '{NR, NR, NR, OK, NR, NR, OK};
            for (int c = 0; c < 7; c++) begin
                if (c < 6) begin
                    dmem_req = 1'b1; dmem_wr = 1'b0; dmem_w = WD; dmem_addr = 32'h10;
                    acc_req = 2'b11; acc_we = 2'b00; acc_addr = {2{14'd4}};
                end else begin
                    idle_inputs();
                end
                @(negedge clk);
                chk($sformatf("rr%0d_aack", c), 32'(aack_r), 32'(x_aack[c]));
                chk($sformatf("rr%0d_dack", c), 32'(dack_r), 32'(x_dack[c]));
                chk($sformatf("rr%0d_arv", c), 32'(arv_r), 32'(x_arv[c]));
                chk($sformatf("rr%0d_dresp", c), 32'(dresp_r), 32'(x_dres[c]));
                if (x_arv[c] != 2'b00)
                    chk($sformatf("rr%0d_ardata", c), ardata_r, 32'h55555555);
                if (x_dres[c] == OK)
                    chk($sformatf("rr%0d_drdata", c), drdata_r, 32'h55555555);
                if (c < 6) begin
                    chk($sformatf("prio%0d_dack", c), 32'(dack_p), 32'h1);
                    chk($sformatf("prio%0d_aack", c), 32'(aack_p), 32'h0);
                end
                $display("rr cycle %0d: dack=%0b aack=%b arv=%b dresp=%0d",
                         c, dack_r, aack_r, arv_r, dresp_r);
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
